// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bus: ID/EX/MEM/WB pipeline status in, stall/forward controls out.
// master = pipeline side (drives stage status), slave = hazard controller.
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_rs1;
    logic [4:0]       ID_rs2;
    logic             ID_rs2_used;
    logic [4:0]       ID_rd;
    logic             ID_rd_used;
    logic [4:0]       EX_rd;
    logic [4:0]       MEM_rd;
    logic [4:0]       WB_rd;
    logic             EX_RF_enable;
    logic             MEM_RF_enable;
    logic             WB_RF_enable;
    logic             EX_load_instr;
    logic             MEM_req;
    logic             dm_ready;
    logic             stall_clr;

    logic             PC_LE;
    logic             nPC_LE;
    logic             IFID_LE;
    logic             CU_S;
    logic             pipe_hold;
    logic [1:0]       fwd_rs1;
    logic [1:0]       fwd_rs2;
    logic [1:0]       fwd_rd;
    logic [CNT_W-1:0] stall_count;
    logic             err_timeout;

    modport master (
        output ID_rs1, ID_rs2, ID_rs2_used, ID_rd, ID_rd_used,
               EX_rd, MEM_rd, WB_rd, EX_RF_enable, MEM_RF_enable, WB_RF_enable,
               EX_load_instr, MEM_req, dm_ready, stall_clr,
        input  PC_LE, nPC_LE, IFID_LE, CU_S, pipe_hold,
               fwd_rs1, fwd_rs2, fwd_rd, stall_count, err_timeout
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_rs2_used, ID_rd, ID_rd_used,
               EX_rd, MEM_rd, WB_rd, EX_RF_enable, MEM_RF_enable, WB_RF_enable,
               EX_load_instr, MEM_req, dm_ready, stall_clr,
        output PC_LE, nPC_LE, IFID_LE, CU_S, pipe_hold,
               fwd_rs1, fwd_rs2, fwd_rd, stall_count, err_timeout
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for a 5-stage pipeline: load-use bubbles, operand
// forwarding selects, data-memory freeze with timeout, stall-cycle counter.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  RUN      | normal flow; may insert a load-use bubble or start a freeze
//  MEM_WAIT | data memory busy; whole pipeline frozen until ready/timeout
module pipeline_hazard_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input logic                         Clk,
    input logic                         R,
    pipeline_hazard_controller_if.slave hz
);

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             err_timeout_q, err_timeout_d;

    logic             le;
    logic             cu_s;
    logic             pipe_hold;
    logic [1:0]       fwd_rs1, fwd_rs2, fwd_rd;

    logic             mem_busy;
    logic             load_use;
    logic             wait_more;

    // Source x matches stage s when s writes a non-zero register equal to x.
    function automatic logic match(input logic [4:0] src, input logic [4:0] rd,
                                   input logic rf_en);
        return (src == rd) && rf_en && (src != 5'd0);
    endfunction

    // Youngest producer wins; a load still in EX cannot forward (bubble covers it).
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic used,
                                           input logic [4:0] ex_rd, input logic ex_en,
                                           input logic ex_ld,
                                           input logic [4:0] mem_rd, input logic mem_en,
                                           input logic [4:0] wb_rd, input logic wb_en);
        logic [1:0] sel;
        sel = 2'b00;
        if (used) begin
            if (match(src, ex_rd, ex_en))        sel = ex_ld ? 2'b00 : 2'b01;
            else if (match(src, mem_rd, mem_en)) sel = 2'b10;
            else if (match(src, wb_rd, wb_en))   sel = 2'b11;
        end
        return sel;
    endfunction

    // Hazard detection terms shared by next-state and output logic.
    always_comb begin
        mem_busy  = hz.MEM_req && !hz.dm_ready;
        load_use  = hz.EX_load_instr &&
                    (match(hz.ID_rs1, hz.EX_rd, hz.EX_RF_enable) ||
                     (hz.ID_rs2_used && match(hz.ID_rs2, hz.EX_rd, hz.EX_RF_enable)) ||
                     (hz.ID_rd_used  && match(hz.ID_rd,  hz.EX_rd, hz.EX_RF_enable)));
        wait_more = !hz.dm_ready && (wait_cnt_q < TIMEOUT);
    end

    // FSM state and wait timer registers.
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // FSM next state, wait timer and sticky timeout flag.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (wait_more) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                    if (!hz.dm_ready) err_timeout_d = 1'b1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Mealy control outputs; reset forces fetch off with a NOP injected.
    always_comb begin
        le        = 1'b0;
        cu_s      = 1'b1;
        pipe_hold = 1'b0;
        if (R) begin
            if ((state_q == RUN && mem_busy) || (state_q == MEM_WAIT && wait_more)) begin
                cu_s      = 1'b0;
                pipe_hold = 1'b1;
            end else if (load_use) begin
                cu_s = 1'b1;
            end else begin
                le   = 1'b1;
                cu_s = 1'b0;
            end
        end
    end

    // Per-source forwarding selects; held at RF while in reset.
    always_comb begin
        fwd_rs1 = 2'b00;
        fwd_rs2 = 2'b00;
        fwd_rd  = 2'b00;
        if (R) begin
            fwd_rs1 = fwd_sel(hz.ID_rs1, 1'b1, hz.EX_rd, hz.EX_RF_enable, hz.EX_load_instr,
                              hz.MEM_rd, hz.MEM_RF_enable, hz.WB_rd, hz.WB_RF_enable);
            fwd_rs2 = fwd_sel(hz.ID_rs2, hz.ID_rs2_used, hz.EX_rd, hz.EX_RF_enable,
                              hz.EX_load_instr, hz.MEM_rd, hz.MEM_RF_enable,
                              hz.WB_rd, hz.WB_RF_enable);
            fwd_rd  = fwd_sel(hz.ID_rd, hz.ID_rd_used, hz.EX_rd, hz.EX_RF_enable,
                              hz.EX_load_instr, hz.MEM_rd, hz.MEM_RF_enable,
                              hz.WB_rd, hz.WB_RF_enable);
        end
    end

    // Stall counter: clear beats increment, saturates at all-ones.
    always_comb begin
        stall_count_d = stall_count_q;
        if (hz.stall_clr)
            stall_count_d = '0;
        else if (!le && (stall_count_q != '1))
            stall_count_d = stall_count_q + 1'b1;
    end

    // Counter and error flag registers.
    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            stall_count_q <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            stall_count_q <= stall_count_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign hz.PC_LE       = le;
    assign hz.nPC_LE      = le;
    assign hz.IFID_LE     = le;
    assign hz.CU_S        = cu_s;
    assign hz.pipe_hold   = pipe_hold;
    assign hz.fwd_rs1     = fwd_rs1;
    assign hz.fwd_rs2     = fwd_rs2;
    assign hz.fwd_rd      = fwd_rd;
    assign hz.stall_count = stall_count_q;
    assign hz.err_timeout = err_timeout_q;

endmodule
